// File: rtl/lba_update_issuer.sv
// Buffers host LBA requests in a small FIFO, optionally drops back-to-back
// duplicates, and issues them to the cache as spaced one-cycle update pulses.
module lba_update_issuer #(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 4,
    parameter bit DEDUP      = 1'b1
) (
    input  logic                     clk_2x,
    input  logic                     rst_2x,
    input  logic                     in_lba_valid,
    output logic                     in_lba_ready,
    input  logic [31:0]              in_LBA,
    output logic [31:0]              out_LBA,
    output logic                     out_update_cache_2x,
    output logic [$clog2(DEPTH):0]   out_fifo_count,
    output logic [15:0]              out_drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES - 1) : 1;
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 2);
    localparam logic [CW-1:0] GAP_ONE  = CW'(1);
    localparam bit            HAS_WAIT = (GAP_CYCLES > 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_last_vld;
    logic [31:0]   r_last_lba;
    logic [15:0]   r_drop_cnt;
    logic [31:0]   r_out_lba;
    logic          r_strobe;
    logic [CW-1:0] r_gap;
    state_t        r_state;

    state_t        w_state_nxt;
    logic          w_accept;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_nonempty;
    logic          w_strobe_nxt;
    logic [31:0]   w_lba_nxt;
    logic [CW-1:0] w_gap_nxt;

    assign in_lba_ready        = (r_count < FULL_CNT);
    assign w_nonempty          = (r_count != '0);
    assign w_accept            = in_lba_valid && in_lba_ready;
    // Dedup compares against the last accepted beat, whether it was pushed or dropped
    assign w_drop              = w_accept && DEDUP && r_last_vld && (in_LBA == r_last_lba);
    assign w_push              = w_accept && !w_drop;
    assign out_LBA             = r_out_lba;
    assign out_update_cache_2x = r_strobe;
    assign out_fifo_count      = r_count;
    assign out_drop_cnt        = r_drop_cnt;

    // FIFO storage write port
    always_ff @(posedge clk_2x) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_LBA;
        end
    end

    // FIFO pointers, occupancy, dedup history and drop counter
    always_ff @(posedge clk_2x) begin
        if (rst_2x) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_last_vld <= 1'b0;
            r_last_lba <= 32'h0000_0000;
            r_drop_cnt <= 16'h0000;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_accept) begin
                r_last_lba <= in_LBA;
                r_last_vld <= 1'b1;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    // Issue FSM state register
    always_ff @(posedge clk_2x) begin
        if (rst_2x) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Issue FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_nonempty) w_state_nxt = ST_ISSUE;
                else            w_state_nxt = ST_IDLE;
            end
            ST_ISSUE: begin
                if (HAS_WAIT) w_state_nxt = ST_WAIT;
                else          w_state_nxt = ST_IDLE;
            end
            ST_WAIT: begin
                // Leaving at count 1 lands the next pop exactly GAP_CYCLES after the last
                if (r_gap <= GAP_ONE) w_state_nxt = ST_IDLE;
                else                  w_state_nxt = ST_WAIT;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Issue FSM output decode: pop, strobe, LBA and gap counter next values
    always_comb begin
        w_pop        = 1'b0;
        w_strobe_nxt = 1'b0;
        w_lba_nxt    = r_out_lba;
        w_gap_nxt    = r_gap;
        case (r_state)
            ST_IDLE: begin
                if (w_nonempty) begin
                    w_pop        = 1'b1;
                    w_strobe_nxt = 1'b1;
                    w_lba_nxt    = r_mem[r_rd_ptr];
                end else begin
                    w_pop        = 1'b0;
                end
            end
            ST_ISSUE: begin
                w_gap_nxt = GAP_LOAD;
            end
            ST_WAIT: begin
                if (r_gap != '0) w_gap_nxt = r_gap - GAP_ONE;
                else             w_gap_nxt = '0;
            end
            default: begin
                w_gap_nxt = '0;
            end
        endcase
    end

    // Registered cache-facing outputs and gap counter
    always_ff @(posedge clk_2x) begin
        if (rst_2x) begin
            r_out_lba <= 32'h0000_0000;
            r_strobe  <= 1'b0;
            r_gap     <= '0;
        end else begin
            r_out_lba <= w_lba_nxt;
            r_strobe  <= w_strobe_nxt;
            r_gap     <= w_gap_nxt;
        end
    end

endmodule

// File: tb/tb_lba_update_issuer.sv
// Randomized and directed bench for lba_update_issuer; two instances
// (defaults, and DEDUP=0/GAP=2/DEPTH=4) against a queue-and-timestamp model.
module tb_lba_update_issuer;

    logic        clk_2x = 1'b0;
    logic        rst_2x;
    logic        in_lba_valid;
    logic [31:0] in_LBA;

    logic        rdy0, stb0, rdy1, stb1;
    logic [31:0] lba0, lba1;
    logic [3:0]  cnt0;
    logic [2:0]  cnt1;
    logic [15:0] drop0, drop1;

    lba_update_issuer u_dut0 (
        .clk_2x(clk_2x), .rst_2x(rst_2x), .in_lba_valid(in_lba_valid),
        .in_lba_ready(rdy0), .in_LBA(in_LBA), .out_LBA(lba0),
        .out_update_cache_2x(stb0), .out_fifo_count(cnt0), .out_drop_cnt(drop0)
    );

    lba_update_issuer #(.DEPTH(4), .GAP_CYCLES(2), .DEDUP(1'b0)) u_dut1 (
        .clk_2x(clk_2x), .rst_2x(rst_2x), .in_lba_valid(in_lba_valid),
        .in_lba_ready(rdy1), .in_LBA(in_LBA), .out_LBA(lba1),
        .out_update_cache_2x(stb1), .out_fifo_count(cnt1), .out_drop_cnt(drop1)
    );

    always #5 clk_2x = ~clk_2x;

    // Reference model: per-instance queue (ring + head/tail) and earliest next pulse cycle
    int          p_depth [2];
    int          p_gap   [2];
    bit          p_dedup [2];
    logic [31:0] m_buf   [2][0:255];
    int          m_head  [2];
    int          m_tail  [2];
    logic [31:0] m_last  [2];
    bit          m_lvld  [2];
    logic [15:0] m_drop  [2];
    logic [31:0] m_out   [2];
    bit          m_stb   [2];
    int          m_next  [2];
    int          cyc;
    int          n_checks;
    int          n_fail;
    int          stb_cnt0;
    int          stb_cnt1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge(input int i);
        int sz;
        bit acc;
        if (rst_2x) begin
            m_head[i] = 0; m_tail[i] = 0; m_lvld[i] = 1'b0; m_last[i] = 32'h0;
            m_drop[i] = 16'h0; m_out[i] = 32'h0; m_stb[i] = 1'b0; m_next[i] = 0;
        end else begin
            sz  = m_tail[i] - m_head[i];
            acc = in_lba_valid && (sz < p_depth[i]);
            if (sz > 0 && cyc >= m_next[i]) begin
                m_out[i]  = m_buf[i][m_head[i] % 256];
                m_head[i] = m_head[i] + 1;
                m_stb[i]  = 1'b1;
                m_next[i] = cyc + p_gap[i];
            end else begin
                m_stb[i]  = 1'b0;
            end
            if (acc) begin
                if (p_dedup[i] && m_lvld[i] && in_LBA == m_last[i]) begin
                    if (m_drop[i] != 16'hFFFF) m_drop[i] = m_drop[i] + 16'd1;
                end else begin
                    m_buf[i][m_tail[i] % 256] = in_LBA;
                    m_tail[i] = m_tail[i] + 1;
                end
                m_last[i] = in_LBA;
                m_lvld[i] = 1'b1;
            end
        end
    endtask

    task automatic step();
        int sz0, sz1;
        @(posedge clk_2x);
        model_edge(0);
        model_edge(1);
        cyc++;
        #1;
        if (stb0) stb_cnt0++;
        if (stb1) stb_cnt1++;
        sz0 = m_tail[0] - m_head[0];
        sz1 = m_tail[1] - m_head[1];
        check("lba0",   lba0,        m_out[0]);
        check("stb0",   32'(stb0),   32'(m_stb[0]));
        check("cnt0",   32'(cnt0),   32'(sz0));
        check("drop0",  32'(drop0),  32'(m_drop[0]));
        check("rdy0",   32'(rdy0),   32'(sz0 < p_depth[0]));
        check("lba1",   lba1,        m_out[1]);
        check("stb1",   32'(stb1),   32'(m_stb[1]));
        check("cnt1",   32'(cnt1),   32'(sz1));
        check("drop1",  32'(drop1),  32'(m_drop[1]));
        check("rdy1",   32'(rdy1),   32'(sz1 < p_depth[1]));
    endtask

    task automatic do_reset();
        rst_2x = 1'b1;
        in_lba_valid = 1'b0;
        step();
        step();
        rst_2x = 1'b0;
        step();
    endtask

    initial begin
        int guard;
        p_depth[0] = 8; p_gap[0] = 4; p_dedup[0] = 1'b1;
        p_depth[1] = 4; p_gap[1] = 2; p_dedup[1] = 1'b0;
        cyc = 0; n_checks = 0; n_fail = 0; stb_cnt0 = 0; stb_cnt1 = 0;
        rst_2x = 1'b1;
        in_lba_valid = 1'b0;
        in_LBA = 32'h0;

        // Reset held for 10 cycles, then released
        repeat (10) step();
        rst_2x = 1'b0;
        step();
        check("post_reset_ready", 32'(rdy0), 32'd1);

        // Single beat
        in_lba_valid = 1'b1;
        in_LBA = 32'h1986_0001;
        step();
        in_lba_valid = 1'b0;
        repeat (12) step();
        check("single_lba", lba0, 32'h1986_0001);

        // Twelve back-to-back beats with valid held
        do_reset();
        stb_cnt0 = 0;
        in_lba_valid = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            in_LBA = 32'h0718_0000 + 32'(k);
            guard = 0;
            while (!rdy0 && guard < 50) begin
                step();
                guard++;
            end
            check("burst_wait_bound", 32'(guard < 50), 32'd1);
            step();
        end
        in_lba_valid = 1'b0;
        repeat (60) step();
        check("burst_strobes", 32'(stb_cnt0), 32'd12);
        check("burst_last_lba", lba0, 32'h0718_000C);

        // Dedup sequence A, A, B
        do_reset();
        stb_cnt0 = 0;
        stb_cnt1 = 0;
        in_lba_valid = 1'b1;
        in_LBA = 32'h1986_0001; step();
        in_LBA = 32'h1986_0001; step();
        in_LBA = 32'h0718_0001; step();
        in_lba_valid = 1'b0;
        repeat (30) step();
        check("dedup_strobes",   32'(stb_cnt0), 32'd2);
        check("dedup_drops",     32'(drop0),    32'd1);
        check("nodedup_strobes", 32'(stb_cnt1), 32'd3);
        check("nodedup_drops",   32'(drop1),    32'd0);

        // Reset during a strobe with entries queued
        do_reset();
        in_lba_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_LBA = 32'h5500_0000 + 32'(k);
            step();
        end
        in_lba_valid = 1'b0;
        guard = 0;
        while (!stb0 && guard < 20) begin
            step();
            guard++;
        end
        check("midreset_strobe_seen", 32'(stb0), 32'd1);
        rst_2x = 1'b1;
        step();
        rst_2x = 1'b0;
        stb_cnt0 = 0;
        repeat (20) step();
        check("midreset_no_strobes", 32'(stb_cnt0), 32'd0);
        check("midreset_lba", lba0, 32'h0);

        // Random traffic with small LBA alphabet and occasional resets
        do_reset();
        for (int n = 0; n < 600; n++) begin
            in_lba_valid = ($urandom_range(0, 9) < 7);
            in_LBA = 32'hA000_0000 | 32'($urandom_range(0, 3));
            rst_2x = ($urandom_range(0, 149) == 0);
            step();
        end
        rst_2x = 1'b0;
        in_lba_valid = 1'b0;
        repeat (60) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lba_update_issuer.md
Name: lba_update_issuer

Overview:
- Upstream feeder for the cache block: accepts host LBA requests on a valid/ready interface and buffers them in a small FIFO.
- Optionally drops back-to-back duplicate LBAs.
- Issues each LBA to the cache as a one-cycle update pulse with the LBA on a 32-bit bus.
- Enforces a minimum start-to-start spacing between pulses so the cache has time to complete each update.
- Drives the cache's LBA input and update-strobe input directly.

Parameters:
- DEPTH, 8: FIFO entries; power of 2, at least 2.
- GAP_CYCLES, 4: minimum cycles from one pulse start to the next; at least 2.
- DEDUP, 1: 1 drops an accepted LBA equal to the previously accepted LBA; 0 disables dropping.

Ports:
- clk_2x  in  1  sole clock; all logic on rising edge.
- rst_2x  in  1  synchronous reset, active-high.
- in_lba_valid  in  1  request valid.
- in_lba_ready  out  1  request ready.
- in_LBA  in  32  requested LBA.
- out_LBA  out  32  LBA to the cache; holds the last issued value between pulses.
- out_update_cache_2x  out  1  one-cycle update strobe to the cache.
- out_fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- out_drop_cnt  out  16  number of deduplicated (dropped) requests.

Behaviour:
- Interface: one clock (clk_2x); reset rst_2x is synchronous and active-high.
- Reset values (sampled at a clock edge with rst_2x=1):
  - out_LBA=0, out_update_cache_2x=0, out_fifo_count=0, out_drop_cnt=0.
  - FIFO pointers=0, last-accepted-valid flag cleared, FSM=IDLE, gap counter=0.
  - in_lba_ready=1 once reset is released.
- Accept:
  - in_lba_ready = (out_fifo_count < DEPTH). It is combinational from the registered count; there is no same-cycle pop lookahead.
  - A beat is accepted when in_lba_valid & in_lba_ready at a rising edge.
- Dedup:
  - If DEDUP=1, the last-accepted flag is set, and in_LBA equals the last accepted LBA: the beat is accepted but not written.
  - out_drop_cnt increments and saturates at 16'hFFFF.
  - Otherwise the beat is pushed to the FIFO.
  - Every accepted beat, dropped or pushed, updates the last-accepted LBA.
  - The comparison is against the last accepted LBA, not the last issued LBA.
- FSM IDLE -> ISSUE -> WAIT -> IDLE:
  - IDLE: if the FIFO is non-empty, pop the head at this edge, load out_LBA with the head, set out_update_cache_2x=1, and go to ISSUE.
  - ISSUE: lasts exactly one cycle. At its end, clear out_update_cache_2x, load the gap counter with GAP_CYCLES-2, and go to WAIT. If GAP_CYCLES=2, go straight to IDLE.
  - WAIT: decrement the counter; at 0 go to IDLE.
- Timing:
  - Latency: beat accepted at edge N into an empty FIFO with FSM in IDLE -> entry visible after N -> pop at N+1 -> strobe high from N+1 to N+2.
  - With a continuous backlog, strobe starts are exactly GAP_CYCLES apart.
  - Issue order is strict FIFO order.
- Occupancy:
  - Push and pop in the same cycle: count unchanged; both pointers advance; pointers wrap modulo DEPTH.
  - Full: in_lba_ready=0, no accept, nothing changes. A pop frees a slot, so in_lba_ready=1 in the following cycle.
  - Empty in IDLE: FSM stays IDLE, strobe stays 0, out_LBA holds.
- Reset mid-operation:
  - All state returns to the reset values at that edge and queued entries are discarded.
  - A strobe in progress is deasserted from that edge.
  - No pulse appears until a new beat is accepted after release.
- out_update_cache_2x is never high for two consecutive cycles.

Test Plan:
1. Hold rst_2x=1 for 10 cycles, then release -> all outputs 0 during reset; in_lba_ready=1 and out_fifo_count=0 after release.
2. Single beat 32'h19860001 accepted at edge N -> strobe high only in the cycle N+1..N+2; out_LBA=32'h19860001 and held afterwards; count returns to 0.
3. Hold valid with 12 LBAs 32'h07180001..0C back-to-back (DEPTH=8, GAP_CYCLES=4):
   - in_lba_ready drops when count reaches 8.
   - Strobes are exactly 4 cycles apart.
   - out_LBA sequence is 01..0C in order; no loss; count ends at 0.
4. Dedup with DEDUP=1, sequence 32'h19860001, 32'h19860001, 32'h07180001 -> 2 strobes, out_drop_cnt=1. With DEDUP=0 -> 3 strobes, out_drop_cnt=0.
5. Queue 5 entries, then assert rst_2x for 1 cycle during a strobe -> strobe 0 from that edge; count 0; no further strobes after release; out_LBA=0.
6. Fill FIFO to DEPTH with valid held high:
   - No accept while full.
   - The pop at the next IDLE edge -> in_lba_ready=1 in the following cycle, one beat accepted, count back to DEPTH.
